alu_result_packer: RTL and testbench

//  Downstream stage of the per-lane ALU submodule. Consumes its 32-bit result stream
//  (valid-qualified, no stall) and packs SEW-sized elements into 32-bit VRF write words

---
 rtl/alu_result_packer_pkg.sv | 24 ++
 rtl/alu_result_packer_result_sync_fifo.sv | 68 ++++++
 rtl/alu_result_packer.sv | 166 ++++++++++++++++
 tb/tb_alu_result_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_packer_pkg.sv
// Shared types for the ALU result packer: element size encoding and FIFO entry layout.
package alu_result_packer_pkg;

  localparam int unsigned VrfAddrW = 9;

  typedef enum logic [1:0] {
    Sew8  = 2'b00,
    Sew16 = 2'b01,
    Sew32 = 2'b10
  } sew_t;

  typedef struct packed {
    logic [VrfAddrW-1:0] addr;
    logic [31:0]         data;
    logic [3:0]          bwe;
    logic                last;
  } vrf_wr_entry_t;

  // The reserved encoding 2'b11 behaves as a full 32-bit element.
  function automatic sew_t decode_sew(input logic [1:0] raw);
    return (raw == 2'b11) ? Sew32 : sew_t'(raw);
  endfunction

endpackage

// File: rtl/alu_result_packer_result_sync_fifo.sv
// Generic synchronous FIFO with synchronous flush; a push into a full FIFO is ignored
// unless a pop happens in the same cycle.
module result_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_packer.sv
// Packs SEW-sized ALU results into 32-bit VRF write words with byte enables, buffered
// through a FIFO that absorbs VRF write-port backpressure.
module alu_result_packer
  import alu_result_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned VRF_ADDR_W = VrfAddrW,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [1:0]            sew_i,
  input  logic [VRF_ADDR_W-1:0] base_addr_i,
  input  logic                  alu_vld_i,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_last_i,
  output logic                  vrf_wvld_o,
  input  logic                  vrf_wrdy_i,
  output logic [VRF_ADDR_W-1:0] vrf_waddr_o,
  output logic [31:0]           vrf_wdata_o,
  output logic [3:0]            vrf_bwe_o,
  output logic                  almost_full_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] AfThresh = CntW'(FIFO_DEPTH - AF_MARGIN);

  sew_t                  sew_q, sew_d;
  logic [VRF_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           pack_data_q, pack_data_d;
  logic [3:0]            pack_bwe_q, pack_bwe_d;
  logic                  busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, af_q, af_d;

  logic [31:0]     elem_data;
  logic [3:0]      elem_bwe;
  logic [1:0]      last_off;
  logic            accept, word_done, pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count, count_nxt;
  vrf_wr_entry_t   push_entry, head_entry;

  // Position the incoming element inside the word being assembled.
  always_comb begin
    elem_data = alu_result_i;
    elem_bwe  = 4'hF;
    last_off  = 2'd0;
    case (sew_q)
      Sew8: begin
        elem_data = {24'b0, alu_result_i[7:0]} << {off_q, 3'b000};
        elem_bwe  = 4'b0001 << off_q;
        last_off  = 2'd3;
      end
      Sew16: begin
        elem_data = {16'b0, alu_result_i[15:0]} << {off_q[0], 4'b0000};
        elem_bwe  = 4'b0011 << {off_q[0], 1'b0};
        last_off  = 2'd1;
      end
      default: ;
    endcase
  end

  assign accept     = busy_q && alu_vld_i && !start_i;
  assign word_done  = accept && ((off_q == last_off) || alu_last_i);
  assign pop        = !fifo_empty && vrf_wrdy_i;
  assign push_entry = '{addr: addr_q, data: pack_data_q | elem_data,
                        bwe: pack_bwe_q | elem_bwe, last: alu_last_i};

  always_comb begin
    count_nxt = fifo_count;
    if (word_done && (!fifo_full || pop) && !pop) count_nxt = fifo_count + CntW'(1);
    else if (!word_done && pop)                   count_nxt = fifo_count - CntW'(1);
    if (start_i) count_nxt = '0;
  end

  always_comb begin
    sew_d       = sew_q;
    addr_d      = addr_q;
    off_d       = off_q;
    pack_data_d = pack_data_q;
    pack_bwe_d  = pack_bwe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    af_d        = (count_nxt >= AfThresh);
    if (start_i) begin
      sew_d       = decode_sew(sew_i);
      addr_d      = base_addr_i;
      off_d       = '0;
      pack_data_d = '0;
      pack_bwe_d  = '0;
      busy_d      = 1'b1;
      ovf_d       = 1'b0;
    end else begin
      if (word_done) begin
        addr_d      = addr_q + VRF_ADDR_W'(1);
        off_d       = '0;
        pack_data_d = '0;
        pack_bwe_d  = '0;
        if (fifo_full && !pop) ovf_d = 1'b1;
      end else if (accept) begin
        off_d       = off_q + 2'd1;
        pack_data_d = push_entry.data;
        pack_bwe_d  = push_entry.bwe;
      end
      if (pop && head_entry.last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sew_q       <= Sew8;
      addr_q      <= '0;
      off_q       <= '0;
      pack_data_q <= '0;
      pack_bwe_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      sew_q       <= sew_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      pack_data_q <= pack_data_d;
      pack_bwe_q  <= pack_bwe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      af_q        <= af_d;
    end
  end

  result_sync_fifo #(
    .Width ($bits(vrf_wr_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (start_i),
    .push_i  (word_done),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Payload is forced to zero when idle so nothing stale leaks out of the FIFO storage.
  assign vrf_wvld_o    = !fifo_empty;
  assign vrf_waddr_o   = vrf_wvld_o ? head_entry.addr : '0;
  assign vrf_wdata_o   = vrf_wvld_o ? head_entry.data : '0;
  assign vrf_bwe_o     = vrf_wvld_o ? head_entry.bwe : '0;
  assign almost_full_o = af_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer; expected VRF words are queued as stimulus is
// driven and compared as the VRF port accepts them.
module tb_alu_result_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [1:0]  sew_i;
  logic [8:0]  base_addr_i;
  logic        alu_vld_i;
  logic [31:0] alu_result_i;
  logic        alu_last_i;
  logic        vrf_wvld_o;
  logic        vrf_wrdy_i;
  logic [8:0]  vrf_waddr_o;
  logic [31:0] vrf_wdata_o;
  logic [3:0]  vrf_bwe_o;
  logic        almost_full_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int passes = 0;
  int fails = 0;
  int total = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_cnt = 0;
  logic [44:0] sb[$];

  alu_result_packer dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .sew_i         (sew_i),
    .base_addr_i   (base_addr_i),
    .alu_vld_i     (alu_vld_i),
    .alu_result_i  (alu_result_i),
    .alu_last_i    (alu_last_i),
    .vrf_wvld_o    (vrf_wvld_o),
    .vrf_wrdy_i    (vrf_wrdy_i),
    .vrf_waddr_o   (vrf_waddr_o),
    .vrf_wdata_o   (vrf_wdata_o),
    .vrf_bwe_o     (vrf_bwe_o),
    .almost_full_o (almost_full_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (rstn && vrf_wvld_o && vrf_wrdy_i) begin
      check("sb_pending", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) check("vrf_word", {vrf_waddr_o, vrf_wdata_o, vrf_bwe_o}, sb.pop_front());
      last_acc_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] s, input logic [8:0] b);
    start_i = 1'b1;
    sew_i = s;
    base_addr_i = b;
    step();
    start_i = 1'b0;
  endtask

  task automatic elem(input logic [31:0] d, input logic l);
    alu_vld_i = 1'b1;
    alu_result_i = d;
    alu_last_i = l;
    step();
    alu_vld_i = 1'b0;
    alu_last_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
    if (seen) check({tag, "_done_lat"}, 64'(cyc - last_acc_cyc), 1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 0);
    check({tag, "_busy_clr"}, 64'(busy_o), 0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wvld"}, 64'(vrf_wvld_o), 0);
    check({tag, "_waddr"}, 64'(vrf_waddr_o), 0);
    check({tag, "_wdata"}, 64'(vrf_wdata_o), 0);
    check({tag, "_bwe"}, 64'(vrf_bwe_o), 0);
    check({tag, "_af"}, 64'(almost_full_o), 0);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_done"}, 64'(done_o), 0);
    check({tag, "_ovf"}, 64'(overflow_o), 0);
  endtask

  initial begin
    int d0;
    bit drained;
    rstn = 1'b0;
    start_i = 1'b0;
    sew_i = 2'b00;
    base_addr_i = '0;
    alu_vld_i = 1'b0;
    alu_result_i = '0;
    alu_last_i = 1'b0;
    vrf_wrdy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    step();

    // sew8: one full word then a one-byte partial word
    vrf_wrdy_i = 1'b1;
    start(2'b00, 9'h010);
    check("t1_busy", 64'(busy_o), 1);
    sb.push_back({9'h010, 32'h44332211, 4'hF});
    sb.push_back({9'h011, 32'h00000055, 4'h1});
    elem(32'h11, 0); elem(32'h22, 0); elem(32'h33, 0); elem(32'h44, 0); elem(32'h55, 1);
    wait_done("t1");

    // sew16 with a partial trailing halfword; upper result bits must be masked
    start(2'b01, 9'h020);
    sb.push_back({9'h020, 32'hBBBBAAAA, 4'hF});
    sb.push_back({9'h021, 32'h0000CCCC, 4'h3});
    elem(32'hFFFFAAAA, 0); elem(32'h1234BBBB, 0); elem(32'h0000CCCC, 1);
    wait_done("t2");

    // sew32 (reserved encoding) under backpressure: fill, overflow, drain across wrap
    vrf_wrdy_i = 1'b0;
    start(2'b11, 9'h1FC);
    for (int i = 0; i < 8; i++) begin
      sb.push_back({9'(9'h1FC + i), 32'hC0DE0000 + 32'(i), 4'hF});
      elem(32'hC0DE0000 + 32'(i), 0);
      check("t3_af", 64'(almost_full_o), 64'(i + 1 >= 4));
    end
    check("t3_wvld", 64'(vrf_wvld_o), 1);
    check("t3_ovf_pre", 64'(overflow_o), 0);
    elem(32'hDEADBEEF, 0);
    check("t3_ovf", 64'(overflow_o), 1);
    vrf_wrdy_i = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      @(negedge clk);
      if (sb.size() == 0) drained = 1'b1;
    end
    check("t3_drained", 64'(drained), 1);
    step();
    check("t3_empty", 64'(vrf_wvld_o), 0);
    check("t3_af_clr", 64'(almost_full_o), 0);
    check("t3_ovf_sticky", 64'(overflow_o), 1);

    // full FIFO with simultaneous push and pop must not overflow
    vrf_wrdy_i = 1'b0;
    start(2'b10, 9'h100);
    check("t4_ovf_clr", 64'(overflow_o), 0);
    for (int i = 0; i < 8; i++) begin
      sb.push_back({9'(9'h100 + i), 32'h5A000000 + 32'(i), 4'hF});
      elem(32'h5A000000 + 32'(i), 0);
    end
    vrf_wrdy_i = 1'b1;
    sb.push_back({9'h108, 32'h5A0000FF, 4'hF});
    elem(32'h5A0000FF, 1);
    check("t4_ovf", 64'(overflow_o), 0);
    wait_done("t4");

    // abort mid-word; restart coincident with a discarded element
    start(2'b00, 9'h040);
    elem(32'h01, 0); elem(32'h02, 0);
    d0 = done_cnt;
    start_i = 1'b1;
    sew_i = 2'b00;
    base_addr_i = 9'h080;
    alu_vld_i = 1'b1;
    alu_result_i = 32'hEE;
    step();
    start_i = 1'b0;
    alu_vld_i = 1'b0;
    check("t5_empty", 64'(vrf_wvld_o), 0);
    sb.push_back({9'h080, 32'hA4A3A2A1, 4'hF});
    elem(32'hA1, 0); elem(32'hA2, 0); elem(32'hA3, 0); elem(32'hA4, 1);
    wait_done("t5");
    check("t5_one_done", 64'(done_cnt - d0), 1);
    elem(32'h77, 1);
    step();
    check("idle_ignored", 64'(vrf_wvld_o), 0);

    // asynchronous reset off the clock edge during a burst
    vrf_wrdy_i = 1'b0;
    start(2'b10, 9'h000);
    for (int i = 0; i < 5; i++) elem(32'h100 + 32'(i), 0);
    check("t6_af_pre", 64'(almost_full_o), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("t6_async");
    sb.delete();
    #3;
    rstn = 1'b1;
    vrf_wrdy_i = 1'b1;
    step();
    step();
    check("t6_post_empty", 64'(vrf_wvld_o), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
